// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// Holds the FSM state enum, opcodes, ALU codes and datapath mux selects.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_ALUOUT = 1'b1;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and instruction fields.
// Ports: alu_op_i, funct3_i, funct7b5_i, op5_i in; alu_control_o out.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] alu_control_o
);

   logic [2:0] funct_ctrl;

   // op[5] separates R-type from I-type: addi never subtracts.
   always_comb begin
      funct_ctrl = ALU_ADD;
      unique case (1'b1)
         (funct3_i == 3'b000):
            funct_ctrl = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
         (funct3_i == 3'b010): funct_ctrl = ALU_SLT;
         (funct3_i == 3'b110): funct_ctrl = ALU_OR;
         (funct3_i == 3'b111): funct_ctrl = ALU_AND;
         default:              funct_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      alu_control_o = ALU_ADD;
      unique case (1'b1)
         (alu_op_i == ALUOP_SUB):   alu_control_o = ALU_SUB;
         (alu_op_i == ALUOP_FUNCT): alu_control_o = funct_ctrl;
         default:                   alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle RISC-V datapath (lw/sw/R/I/beq).
// Ports: op/funct fields, zero, mem_ready in; datapath controls, illegal, state out.
module multicycle_control
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       illegal,
   output logic [3:0] state
);

   state_e     state_q, state_d;
   logic [1:0] alu_op;
   logic       pcw, mw, irw, rw, ill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      alu_op    = ALUOP_ADD;
      pcw       = 1'b0;
      mw        = 1'b0;
      irw       = 1'b0;
      rw        = 1'b0;
      ill       = 1'b0;
      AdrSrc    = ADR_PC;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ImmSrc    = IMM_I;
      unique case (state_q)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            // Only Mealy path: commit PC+4 and IR when memory answers.
            irw = mem_ready;
            pcw = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_BEQ) ? IMM_B : IMM_I;
            unique case (1'b1)
               (op == OP_LW), (op == OP_SW): state_d = S_MEMADR;
               (op == OP_R):   state_d = S_EXECUTER;
               (op == OP_I):   state_d = S_EXECUTEI;
               (op == OP_BEQ): state_d = S_BEQ;
               default: begin
                  ill     = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = ADR_ALUOUT;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_MEMDATA;
            rw        = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc = ADR_ALUOUT;
            mw     = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RD1;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rw      = 1'b1;
            state_d = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RD1;
            alu_op  = ALUOP_SUB;
            pcw     = zero;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Enables are masked by reset so nothing commits while rst_n is low,
   // including a write strobe that was mid-flight.
   assign PCWrite  = pcw & rst_n;
   assign MemWrite = mw & rst_n;
   assign IRWrite  = irw & rst_n;
   assign RegWrite = rw & rst_n;
   assign illegal  = ill & rst_n;
   assign state    = state_q;

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .op5_i         (op[5]),
      .alu_control_o (ALUControl)
   );

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main controller for the multicycle RISC-V core. A Moore-style FSM sequences one shared ALU, a unified instruction/data memory and the immediate extender across several cycles per instruction. An ALU-decode sub-block drives ALUControl. Supported instructions: lw, sw, R-type ALU, I-type ALU and beq. Memory accesses stall on a ready handshake.

## Interface
- No parameters; instruction encodings are fixed RV32I.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from IR; valid from DECODE onward
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = memory data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 = I, 01 = S, 10 = B. The sign_extend select widens to 2 bits; bit-0 meaning is unchanged.
- RegWrite  out  1  register file write enable
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state (debug)

## Operation
- Any output not listed for a state is 0. ALUOp is internal: 00 = add, 01 = sub, 10 = funct-decoded.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00, IRWrite=PCWrite=mem_ready.
  - Go to DECODE when mem_ready=1; otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This computes the branch target. ImmSrc=10 if op=beq, else 00.
  - lw (0000011) or sw (0100011) -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 -> BEQ.
  - Any other opcode -> FETCH with illegal=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=01 for sw, 00 for lw. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held while mem_ready=0. -> FETCH on mem_ready.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero -> FETCH.
- ALU decode for ALUOp=10, by funct3:
  - 000: sub if funct7b5 & op[5], else add.
  - 010: slt. 110: or. 111: and.
  - Any other funct3: add, with no illegal flag.
- The state encoding is a package enum; the `state` port carries its 4-bit value.

## Timing
- Reset, asynchronous: state=FETCH immediately.
  - PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0 while rst_n=0, regardless of mem_ready.
  - Other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; a MemWrite in progress drops in the same cycle.
- Latency with mem_ready held at 1:
  - lw: 5 cycles. sw, R-type, I-type: 4 cycles. beq: 3 cycles. Illegal opcode: 2 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No timeout.
- The mem_ready gating of IRWrite and PCWrite in FETCH is combinational. It is the only Mealy path. All other outputs depend only on state and the registered-IR fields.
- State updates on the rising clk edge. Outputs for a state are valid throughout that cycle.

## Structure
- Package riscv_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ;
  - ALUControl codes;
  - ImmSrc codes;
  - mux-select codes for AdrSrc, ResultSrc, ALUSrcA and ALUSrcB.
- Sub-module alu_decoder is combinational: ALUOp, funct3, funct7b5 and op[5] in; ALUControl out.
- The top module holds the state register, next-state logic and output decode.

## Test plan
- Reset is asserted while mem_ready=1 -> state=FETCH; PCWrite=IRWrite=MemWrite=RegWrite=0; ALUSrcB=10 is maintained.
- lw (op=0000011), mem_ready=1 constantly -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
- sw with mem_ready low for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles; AdrSrc=1 throughout; ImmSrc=01 in MEMADR; return to FETCH after that.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. I-type addi with funct7b5=1 -> ALUControl=000. funct3=110 -> 011.
- beq, checked twice: with zero=1 -> PCWrite=1 in BEQ; with zero=0 -> PCWrite=0. ImmSrc=10 in DECODE in both cases.
- op=1111111 -> illegal=1 for one cycle in DECODE, then FETCH. Separately, rst_n is dropped during MEMWRITE -> MemWrite falls asynchronously and state=FETCH.
